// File: rtl/rr_mux_nto1_pkt_pkg.sv
// Shared arbitration helpers: index width and one-hot conversions.
// Other arbiters in the design reuse these.
package rr_mux_nto1_pkt_pkg;

    // Upper bound on channel count that the one-hot helpers can handle.
    localparam int MAX_SIZE = 32;

    // Number of bits needed to hold a channel index (at least 1).
    function automatic int idx_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Index -> one-hot vector of MAX_SIZE bits; callers slice to their width.
    function automatic logic [MAX_SIZE-1:0] onehot(input int idx);
        logic [MAX_SIZE-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // One-hot vector -> index of its set bit (0 when the vector is empty).
    function automatic int onehot_to_idx(input logic [MAX_SIZE-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < MAX_SIZE; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_mux_nto1_pkt_arbiter.sv
// One-hot round-robin arbiter with packet lock.
// Unlocked: first requester at or above prio, wrapping. Locked: only the
// locked channel can be granted, and only while it requests.
module rr_arbiter_onehot #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] request,
    input  logic [SIZE-1:0] prio,
    input  logic            lock_en,
    input  logic [SIZE-1:0] lock_gnt,
    output logic [SIZE-1:0] grant
);

    logic [2*SIZE-1:0] dbl;
    logic [2*SIZE-1:0] dbl_gnt;

    // Double-width scan: subtracting prio borrows up to the first request at
    // or above prio; the duplicated upper half supplies the wrap-around.
    always_comb begin
        dbl     = {request, request};
        dbl_gnt = dbl & ~(dbl - {{SIZE{1'b0}}, prio});
        if (lock_en) begin
            grant = lock_gnt & request;
        end else begin
            grant = dbl_gnt[SIZE-1:0] | dbl_gnt[2*SIZE-1:SIZE];
        end
    end

endmodule

// File: rtl/rr_mux_nto1_pkt.sv
// Registered N-to-1 packet mux with round-robin arbitration.
// Handshake: a beat moves on a channel in any cycle where valid and ready are
// both high at the rising edge; valid never waits on ready, and a source
// holds data/last stable while valid is high and ready is low.
module rr_mux_nto1_pkt
    import rr_mux_nto1_pkt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SIZE  = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [WIDTH*SIZE-1:0] in_data,
    input  logic [SIZE-1:0]       in_valid,
    input  logic [SIZE-1:0]       in_last,
    output logic [SIZE-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [SIZE-1:0]       grant
);

    localparam logic [MAX_SIZE-1:0] PRIO_RST_FULL = onehot(0);
    localparam logic [SIZE-1:0]     PRIO_RST      = PRIO_RST_FULL[SIZE-1:0];

    logic [SIZE-1:0]  prio;
    logic             locked;
    logic [SIZE-1:0]  lock_gnt;
    logic             can_load;
    logic             in_xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic [SIZE-1:0]  prio_next;

    rr_arbiter_onehot #(
        .SIZE (SIZE)
    ) u_arb (
        .request  (in_valid),
        .prio     (prio),
        .lock_en  (locked),
        .lock_gnt (lock_gnt),
        .grant    (grant)
    );

    assign can_load  = ~out_valid | out_ready;
    assign in_ready  = grant & {SIZE{can_load}};
    assign in_xfer   = |(in_valid & in_ready);
    // Channel after the winner becomes highest priority (SIZE is a power of 2).
    assign prio_next = {grant[SIZE-2:0], grant[SIZE-1]};

    // Decoded AND-OR select of the granted channel's data and last flag.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int j = 0; j < SIZE; j++) begin
            sel_data = sel_data | (in_data[j*WIDTH +: WIDTH] & {WIDTH{grant[j]}});
            sel_last = sel_last | (in_last[j] & grant[j]);
        end
    end

    // Output register plus lock/priority state; load and drain may coincide.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            prio      <= PRIO_RST;
            locked    <= 1'b0;
            lock_gnt  <= '0;
        end else if (in_xfer) begin
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_valid <= 1'b1;
            if (sel_last) begin
                locked <= 1'b0;
                prio   <= prio_next;
            end else begin
                locked   <= 1'b1;
                lock_gnt <= grant;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_nto1_pkt.sv
// Directed bench for rr_mux_nto1_pkt (WIDTH=4, SIZE=4).
module tb_rr_mux_nto1_pkt;

    localparam int WIDTH = 4;
    localparam int SIZE  = 4;

    logic                  clock;
    logic                  reset_n;
    logic [WIDTH*SIZE-1:0] in_data;
    logic [SIZE-1:0]       in_valid;
    logic [SIZE-1:0]       in_last;
    logic [SIZE-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;
    logic [SIZE-1:0]       grant;

    int total;
    int bad;

    rr_mux_nto1_pkt #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant)
    );

    // Clock: 10 time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Apply inputs and let combinational outputs settle.
    task automatic drive(input logic [SIZE-1:0] v, input logic [SIZE-1:0] l,
                         input logic [WIDTH*SIZE-1:0] d);
        in_valid = v;
        in_last  = l;
        in_data  = d;
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        in_data   = 16'h3210;

        // Reset with every channel valid.
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_grant", grant, 4'b0001);
        reset_n = 1'b1;
        #1;
        check("first_grant", grant, 4'b0001);

        // Round-robin over single-beat packets: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_grant%0d", k), grant, 4'b0001 << (k % 4));
            step();
            check($sformatf("rr_data%0d", k), out_data, k % 4);
            check($sformatf("rr_valid%0d", k), out_valid, 1);
            check($sformatf("rr_last%0d", k), out_last, 1);
        end
        // prio now points at ch1.

        // Single ch1 beat moves prio to ch2.
        drive(4'b0010, 4'b0010, 16'h0010);
        step();
        check("pre_lock_data", out_data, 1);

        // Ch2 three-beat packet with ch0/ch1 continuously valid.
        for (int b = 0; b < 3; b++) begin
            drive(4'b0111, (b == 2) ? 4'b0100 : 4'b0000,
                  {4'h0, 4'(5 + b), 4'h1, 4'h0});
            check($sformatf("lock_grant%0d", b), grant, 4'b0100);
            step();
            check($sformatf("lock_data%0d", b), out_data, 5 + b);
            check($sformatf("lock_last%0d", b), out_last, (b == 2) ? 1 : 0);
        end
        // After the packet: ch3 if valid, else ch0.
        drive(4'b1011, 4'b1111, 16'h3210);
        check("after_lock_ch3", grant, 4'b1000);
        drive(4'b0011, 4'b1111, 16'h3210);
        check("after_lock_ch0", grant, 4'b0001);
        step();
        check("after_lock_data", out_data, 0);
        // prio now points at ch1.

        // Bubble under lock: ch1 mid-packet, ch0 waiting.
        drive(4'b0011, 4'b0000, 16'h0090);
        check("bub_grant0", grant, 4'b0010);
        step();
        check("bub_data0", out_data, 9);
        for (int c = 0; c < 2; c++) begin
            drive(4'b0001, 4'b0001, 16'h0000);
            check($sformatf("bub_grant_gap%0d", c), grant, 4'b0000);
            check($sformatf("bub_ready_gap%0d", c), in_ready, 4'b0000);
            step();
            check($sformatf("bub_valid_gap%0d", c), out_valid, 0);
        end
        drive(4'b0011, 4'b0010, 16'h00a0);
        check("bub_grant_end", grant, 4'b0010);
        step();
        check("bub_data_end", out_data, 4'ha);
        check("bub_last_end", out_last, 1);
        drive(4'b0001, 4'b0001, 16'h0000);
        check("bub_then_ch0", grant, 4'b0001);

        // Empty the output register before backpressure.
        drive(4'b0000, 4'b0000, 16'h0000);
        step();
        check("idle_valid", out_valid, 0);

        // Backpressure: out_ready low for 5 cycles with ch0 valid.
        out_ready = 1'b0;
        drive(4'b0001, 4'b0001, 16'h000a);
        check("bp_ready_empty", in_ready, 4'b0001);
        step();
        drive(4'b0001, 4'b0001, 16'h000b);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("bp_ready%0d", c), in_ready, 4'b0000);
            check($sformatf("bp_data%0d", c), out_data, 4'ha);
            check($sformatf("bp_valid%0d", c), out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 4'b0001);
        step();
        check("bp_drain_load_data", out_data, 4'hb);
        check("bp_drain_load_valid", out_valid, 1);
        // prio now points at ch1.

        // Ch2 single beat moves prio to ch3.
        drive(4'b0100, 4'b0100, 16'h0200);
        step();
        check("pre_rst_data", out_data, 2);

        // Ch3 4-beat packet, reset after two beats; ch0 also valid.
        drive(4'b1001, 4'b0000, 16'hd00c);
        check("rmp_grant", grant, 4'b1000);
        step();
        step();
        check("rmp_data", out_data, 4'hd);
        reset_n = 1'b0;
        step();
        check("rmp_rst_valid", out_valid, 0);
        check("rmp_rst_data", out_data, 0);
        reset_n = 1'b1;
        #1;
        check("rmp_release_grant", grant, 4'b0001);
        step();
        check("rmp_release_data", out_data, 4'hc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_nto1_pkt.md
# rr_mux_Nto1_pkt

Registered N-to-1 packet multiplexer with integrated round-robin arbitration and valid/ready handshakes on every channel. Successor to the combinational decoded-select mux. It selects among SIZE input channels internally, keeps a channel's grant for a whole packet (until `in_last`), and drives one output register stage. It sits at router/injection-port merge points, where several sources share one downstream link.

## Interface
- `WIDTH`, default 4: data bits per channel.
- `SIZE`, default 4: number of input channels; power of 2, ≥2.
- `clock` in 1: sole clock, all state on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `in_data` in WIDTH*SIZE: channel j occupies bits [j*WIDTH +: WIDTH].
- `in_valid` in SIZE: per-channel valid.
- `in_last` in SIZE: per-channel end-of-packet flag, qualified by `in_valid`.
- `in_ready` out SIZE: per-channel ready; at most one bit set.
- `out_data` out WIDTH: registered selected data.
- `out_valid` out 1: registered valid.
- `out_last` out 1: registered end-of-packet.
- `out_ready` in 1: downstream ready.
- `grant` out SIZE: one-hot current grant, combinational; all-zero when idle. Debug/observability.

## Operation
- Transfer on channel j: `in_valid[j] & in_ready[j]`. Output transfer: `out_valid & out_ready`.
- `can_load = ~out_valid | out_ready`.
- `in_ready[j] = grant[j] & can_load`.
- State:
  - `prio` (one-hot SIZE, highest-priority channel).
  - `locked` (1 bit).
  - `lock_gnt` (one-hot SIZE).
- Arbitration when unlocked: `grant` = first channel with `in_valid` set, scanning from `prio` upward with wrap (j = prio, prio+1, …, SIZE-1, 0, …).
- Arbitration when locked: `grant = lock_gnt & in_valid`. No other channel is granted, even if `lock_gnt`'s valid is low (bubble).
- On input transfer from channel j:
  - Output register loads `in_data` channel j and `in_last[j]`; `out_valid` ← 1.
  - `in_last[j] = 0`: `locked` ← 1, `lock_gnt` ← onehot(j).
  - `in_last[j] = 1`: `locked` ← 0, `prio` ← onehot((j+1) mod SIZE).
- Output transfer without input transfer: `out_valid` ← 0; data/last hold.
- No transfer: all state holds. `out_data`/`out_last` are stable while `out_valid & ~out_ready`.
- Data selection is AND-OR with the one-hot grant, same decoded form as the predecessor.
- Single-beat packets (`in_last` = 1 on first beat) never lock.

## Timing
- Reset (`reset_n` = 0 at edge):
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - `prio`=onehot(0), `locked`=0, `lock_gnt`=0.
  - Combinational outputs follow from this state: `grant`/`in_ready` reflect arbitration from channel 0; `in_ready` is nonzero only if some `in_valid` is set.
- Reset mid-packet drops the lock and the output register contents unconditionally.
- Latency: input transfer at edge N → `out_valid` high after edge N.
- Throughput: 1 beat/cycle when `out_ready` is held high. The simultaneous output drain plus input load in one cycle is required.
- `grant`/`in_ready` depend combinationally on `in_valid`, `out_valid`, `out_ready` and state. No combinational path from `in_data` to any output.
- `prio` changes only on a last-beat transfer, so fairness is per packet, not per beat.

## Structure
- Sub-module `rr_arbiter_onehot` (parameter SIZE):
  - Inputs: request, `prio`, `lock_en`, `lock_gnt`.
  - Output: one-hot grant.
  - Implementation: double-width masked priority scan.
- Shared package holds `clog2`-based index width and the `onehot`/`onehot_to_idx` helper functions, reused by other arbiters in the design.
- Top-level file holds the output register, lock/prio state and AND-OR data select.

## Test plan
- **Reset:** hold `reset_n`=0 with all `in_valid`=1 → `out_valid`=0, `out_data`=0. Release → first grant=4'b0001.
- **Round-robin, single-beat:** SIZE=4, all channels valid with last=1, data=channel index, `out_ready`=1 → `out_data` sequence 0,1,2,3,0 on consecutive cycles.
- **Packet lock:**
  - Ch2 sends 3 beats (last on beat 3) while ch0/ch1 are continuously valid → three ch2 beats contiguous on output.
  - Then ch3 is granted if valid, else ch0.
- **Bubble under lock:** ch1 mid-packet drops `in_valid` for 2 cycles while ch0 is valid → `in_ready[0]` stays 0; output shows no ch0 beat until ch1's last beat.
- **Backpressure:** `out_ready`=0 for 5 cycles with ch0 valid → one beat captured, `out_data` stable, `in_ready`=0. Release → drain and load in the same cycle.
- **Reset mid-packet:** assert `reset_n`=0 during a 4-beat ch3 packet → after release `locked`=0 and arbitration restarts from channel 0.
